// File: rtl/pwm_multichannel.sv
// pwm_multichannel: N independent pulse generators with per-channel high/low time and period count.
// Each channel latches its configuration on an accepted start and runs from that shadow copy.
module pwm_multichannel #(
  parameter int NUM_CHANNELS = 8,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CHANNELS-1:0]       gen_start,
  input  logic [NUM_CHANNELS-1:0]       gen_stop,
  input  logic [NUM_CHANNELS*CNT_W-1:0] high_cycles,
  input  logic [NUM_CHANNELS*CNT_W-1:0] low_cycles,
  input  logic [NUM_CHANNELS*CNT_W-1:0] period_count,
  output logic [NUM_CHANNELS-1:0]       gen_pin,
  output logic [NUM_CHANNELS-1:0]       gen_busy,
  output logic [NUM_CHANNELS-1:0]       gen_done
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    state_t state, nxt_state, restart;
    logic [CNT_W-1:0] cnt, nxt_cnt, pcnt, nxt_pcnt;
    logic [CNT_W-1:0] sh_high, nxt_high, sh_low, nxt_low, sh_count, nxt_count;
    logic [CNT_W-1:0] in_high, in_low, in_count;
    logic running, high_end, low_end, period_end, last, accept;
    logic pin_q, busy_q, done_q;
    assign in_high  = high_cycles[c*CNT_W +: CNT_W];
    assign in_low   = low_cycles[c*CNT_W +: CNT_W];
    assign in_count = period_count[c*CNT_W +: CNT_W];
    assign running    = (state == HIGH) || (state == LOW);
    assign high_end   = (state == HIGH) && (cnt == sh_high - CNT_W'(1));
    assign low_end    = (state == LOW) && (cnt == sh_low - CNT_W'(1));
    // with zero low time the period ends at the end of the high phase
    assign period_end = low_end || (high_end && (sh_low == '0));
    assign last       = (sh_count != '0) && (pcnt + CNT_W'(1) == sh_count);
    assign restart    = (sh_high == '0) ? LOW : HIGH;
    assign accept     = !running && gen_start[c] && !gen_stop[c] && ((in_high | in_low) != '0);
    always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_pcnt  = pcnt;
      nxt_high  = sh_high;
      nxt_low   = sh_low;
      nxt_count = sh_count;
      if (gen_stop[c] && running) begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end else if (accept) begin
        nxt_high  = in_high;
        nxt_low   = in_low;
        nxt_count = in_count;
        nxt_cnt   = '0;
        nxt_pcnt  = '0;
        nxt_state = (in_high == '0) ? LOW : HIGH;
      end else if (period_end) begin
        nxt_cnt   = '0;
        nxt_pcnt  = pcnt + CNT_W'(1);
        nxt_state = last ? DONE : restart;
      end else if (high_end) begin
        nxt_cnt   = '0;
        nxt_state = LOW;
      end else if (running) begin
        nxt_cnt = cnt + CNT_W'(1);
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= IDLE;
        cnt      <= '0;
        pcnt     <= '0;
        sh_high  <= '0;
        sh_low   <= '0;
        sh_count <= '0;
        pin_q    <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        state    <= nxt_state;
        cnt      <= nxt_cnt;
        pcnt     <= nxt_pcnt;
        sh_high  <= nxt_high;
        sh_low   <= nxt_low;
        sh_count <= nxt_count;
        pin_q    <= nxt_state == HIGH;
        busy_q   <= (nxt_state == HIGH) || (nxt_state == LOW);
        done_q   <= nxt_state == DONE;
      end
    end
    assign gen_pin[c]  = pin_q;
    assign gen_busy[c] = busy_q;
    assign gen_done[c] = done_q;
  end
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: directed stimulus pushes expected output transitions into a queue;
// a negedge monitor pops and compares every observed change of {gen_pin, gen_busy, gen_done}.
module tb_pwm_multichannel;
  localparam int N = 8;
  localparam int W = 16;
  typedef struct {
    int cyc;
    int ch;
    logic [2:0] v;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] gen_start = '0, gen_stop = '0;
  logic [N*W-1:0] high_cycles = '0, low_cycles = '0, period_count = '0;
  logic [N-1:0] gen_pin, gen_busy, gen_done;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  ev_t q[$];
  logic [2:0] exp_state [N];
  logic [2:0] prev [N];
  int k;

  pwm_multichannel #(.NUM_CHANNELS(N), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .gen_start(gen_start), .gen_stop(gen_stop),
    .high_cycles(high_cycles), .low_cycles(low_cycles), .period_count(period_count),
    .gen_pin(gen_pin), .gen_busy(gen_busy), .gen_done(gen_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int ch, input int at, input logic p, input logic b, input logic d);
    ev_t e;
    e.cyc = at;
    e.ch = ch;
    e.v = {p, b, d};
    q.push_back(e);
    exp_state[ch] = {p, b, d};
  endtask

  task automatic push_run(input int ch, input int k0, input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      push(ch, k0 + p*(h+l), 1'b1, 1'b1, 1'b0);
      push(ch, k0 + p*(h+l) + h, 1'b0, 1'b1, 1'b0);
    end
    push(ch, k0 + n*(h+l), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic set_cfg(input int ch, input int h, input int l, input int n);
    high_cycles[ch*W +: W] = W'(h);
    low_cycles[ch*W +: W] = W'(l);
    period_count[ch*W +: W] = W'(n);
  endtask

  task automatic strobe(input logic [N-1:0] st, input logic [N-1:0] sp);
    gen_start = st;
    gen_stop = sp;
    @(negedge clk);
    gen_start = '0;
    gen_stop = '0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < N; c++) begin
        logic [2:0] cur;
        int idx;
        cur = {gen_pin[c], gen_busy[c], gen_done[c]};
        if (cur != prev[c]) begin
          idx = -1;
          for (int i = 0; i < q.size(); i++) begin
            if (q[i].ch == c) begin
              idx = i;
              break;
            end
          end
          n_checks++;
          if (idx < 0) begin
            n_fail++;
            $display("FAIL unexpected ch%0d: pin/busy/done=%b at cycle %0d, no transition expected", c, cur, cyc);
          end else begin
            if (q[idx].cyc != cyc || q[idx].v != cur) begin
              n_fail++;
              $display("FAIL transition ch%0d: got %b at cycle %0d expected %b at cycle %0d",
                       c, cur, cyc, q[idx].v, q[idx].cyc);
            end
            q.delete(idx);
          end
          prev[c] = cur;
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < N; c++) begin
      exp_state[c] = '0;
      prev[c] = '0;
    end
    wait_cyc(3);
    rst_n = 1'b1;
    check("reset_pin", int'(gen_pin), 0);
    check("reset_busy", int'(gen_busy), 0);
    check("reset_done", int'(gen_done), 0);
    mon_en = 1'b1;
    // 50/50 x2 on ch0
    set_cfg(0, 50, 50, 2);
    k = cyc + 1;
    push_run(0, k, 50, 50, 2);
    strobe(8'h01, 8'h00);
    wait_cyc(210);
    check("ch0_done", int'(gen_done[0]), 1);
    // 0% duty on ch1, all-zero start on ch3 ignored
    set_cfg(1, 0, 10, 1);
    set_cfg(3, 0, 0, 5);
    k = cyc + 1;
    push(1, k, 1'b0, 1'b1, 1'b0);
    push(1, k + 10, 1'b0, 1'b0, 1'b1);
    strobe(8'h0A, 8'h00);
    check("ch3_busy_ignored", int'(gen_busy[3]), 0);
    wait_cyc(15);
    check("ch3_done_ignored", int'(gen_done[3]), 0);
    // 100% duty continuous on ch2, then stop
    set_cfg(2, 25, 0, 0);
    k = cyc + 1;
    push(2, k, 1'b1, 1'b1, 1'b0);
    strobe(8'h04, 8'h00);
    wait_cyc(999);
    push(2, cyc + 1, 1'b0, 1'b0, 1'b0);
    strobe(8'h00, 8'h04);
    wait_cyc(5);
    check("ch2_done_after_stop", int'(gen_done[2]), 0);
    // all channels on one edge, three periods each
    set_cfg(0, 100, 100, 3);
    set_cfg(1, 50, 150, 3);
    set_cfg(2, 150, 50, 3);
    set_cfg(3, 60, 120, 3);
    set_cfg(4, 120, 60, 3);
    set_cfg(5, 40, 160, 3);
    set_cfg(6, 160, 40, 3);
    set_cfg(7, 180, 20, 3);
    k = cyc + 1;
    push_run(0, k, 100, 100, 3);
    push_run(1, k, 50, 150, 3);
    push_run(2, k, 150, 50, 3);
    push_run(3, k, 60, 120, 3);
    push_run(4, k, 120, 60, 3);
    push_run(5, k, 40, 160, 3);
    push_run(6, k, 160, 40, 3);
    push_run(7, k, 180, 20, 3);
    strobe(8'hFF, 8'h00);
    check("all_rise_aligned", int'(gen_pin), 255);
    wait_cyc(610);
    check("all_done", int'(gen_done), 255);
    // ch4: restart and config change while busy are ignored
    set_cfg(4, 90, 10, 0);
    k = cyc + 1;
    push(4, k, 1'b1, 1'b1, 1'b0);
    push(4, k + 90, 1'b0, 1'b1, 1'b0);
    push(4, k + 100, 1'b1, 1'b1, 1'b0);
    push(4, k + 190, 1'b0, 1'b1, 1'b0);
    push(4, k + 200, 1'b1, 1'b1, 1'b0);
    strobe(8'h10, 8'h00);
    wait_cyc(19);
    strobe(8'h10, 8'h00);
    set_cfg(4, 5, 10, 0);
    wait_cyc(229);
    push(4, k + 250, 1'b0, 1'b0, 1'b0);
    strobe(8'h00, 8'h10);
    wait_cyc(5);
    strobe(8'h10, 8'h10);
    wait_cyc(5);
    check("ch4_start_stop_idle", int'(gen_busy[4]), 0);
    // ch5: async reset mid-high
    set_cfg(5, 40, 60, 0);
    k = cyc + 1;
    push(5, k, 1'b1, 1'b1, 1'b0);
    strobe(8'h20, 8'h00);
    wait_cyc(10);
    for (int c = 0; c < N; c++)
      if (exp_state[c] != 3'b000) push(c, cyc + 1, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 check("async_reset_pin5", int'(gen_pin[5]), 0);
    check("async_reset_done", int'(gen_done), 0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(20);
    check("post_reset_pin", int'(gen_pin), 0);
    check("post_reset_busy", int'(gen_busy), 0);
    check("post_reset_done", int'(gen_done), 0);
    wait_cyc(2);
    foreach (q[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing ch%0d: transition to %b at cycle %0d never observed", q[i].ch, q[i].v, q[i].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
